wb_port_arbiter: RTL and testbench

// Shares the single register-file write port between the in-order writeback stage and a

---
 rtl/wb_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// writeback stage and a long-latency unit whose results arrive out of band.
// Unit results wait in a small FIFO and drain into idle write-port slots; if
// the FIFO fills or its head waits too long, writeback is stalled to force a drain.
//
// Handshake: a long-latency result transfers on any cycle where i_lu_valid and
// o_lu_ready are both high. o_lu_ready depends only on registered occupancy,
// so it never depends combinationally on i_lu_valid. Once the producer raises
// valid, it holds valid and its payload until that transfer cycle.
module wb_port_arbiter #(
    parameter int NUM_REGS  = 32,
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 2,
    parameter int MAX_WAIT  = 4,
    localparam int RW = $clog2(NUM_REGS),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                 i_aclk,
    input  logic                 i_areset_n,
    input  logic                 i_wb_regwrite,
    input  logic [RW-1:0]        i_wb_rdest,
    input  logic [DATA_SIZE-1:0] i_wb_data,
    input  logic                 i_lu_valid,
    output logic                 o_lu_ready,
    input  logic [RW-1:0]        i_lu_rdest,
    input  logic [DATA_SIZE-1:0] i_lu_data,
    input  logic [RW-1:0]        i_rs1,
    input  logic [RW-1:0]        i_rs2,
    output logic                 o_rs1_busy,
    output logic                 o_rs2_busy,
    output logic                 o_wb_stall,
    output logic                 o_rf_we,
    output logic [RW-1:0]        o_rf_waddr,
    output logic [DATA_SIZE-1:0] o_rf_wdata,
    output logic                 o_dbg_state,
    output logic [CW-1:0]        o_dbg_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [AW-1:0] MAX_WAIT_C = AW'(MAX_WAIT);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [AW-1:0]        age_q, age_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]        mem_rdest_q [DEPTH];
    logic [RW-1:0]        mem_rdest_d [DEPTH];
    logic [DATA_SIZE-1:0] mem_data_q  [DEPTH];
    logic [DATA_SIZE-1:0] mem_data_d  [DEPTH];

    logic lu_keep;
    logic push;
    logic pop;
    logic bypass;
    logic rs1_hit;
    logic rs2_hit;
    logic [PW-1:0] idx;

    // Write-port arbitration and handshake; all outputs are zero-latency.
    always_comb begin
        o_lu_ready = 1'b0;
        o_rf_we    = 1'b0;
        o_rf_waddr = '0;
        o_rf_wdata = '0;
        pop        = 1'b0;
        push       = 1'b0;
        bypass     = 1'b0;
        lu_keep    = 1'b0;
        if (i_areset_n) begin
            o_lu_ready = (count_q != DEPTH_C);
            // Results aimed at x0 are accepted but never stored.
            lu_keep    = i_lu_valid && o_lu_ready && (i_lu_rdest != '0);
            if (state_q == ST_NORMAL) begin
                if (i_wb_regwrite && (i_wb_rdest != '0)) begin
                    o_rf_we    = 1'b1;
                    o_rf_waddr = i_wb_rdest;
                    o_rf_wdata = i_wb_data;
                end else if (count_q != '0) begin
                    pop        = 1'b1;
                    o_rf_we    = 1'b1;
                    o_rf_waddr = mem_rdest_q[rd_ptr_q];
                    o_rf_wdata = mem_data_q[rd_ptr_q];
                end else if (lu_keep) begin
                    bypass     = 1'b1;
                    o_rf_we    = 1'b1;
                    o_rf_waddr = i_lu_rdest;
                    o_rf_wdata = i_lu_data;
                end
            end else begin
                // Writeback is held, so the port belongs to the FIFO head.
                if (count_q != '0) begin
                    pop        = 1'b1;
                    o_rf_we    = 1'b1;
                    o_rf_waddr = mem_rdest_q[rd_ptr_q];
                    o_rf_wdata = mem_data_q[rd_ptr_q];
                end
            end
            push = lu_keep && !bypass;
        end
    end

    // FIFO bookkeeping, head age and NORMAL/FORCE next state.
    always_comb begin
        count_d     = count_q;
        age_d       = age_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        state_d     = state_q;
        mem_rdest_d = mem_rdest_q;
        mem_data_d  = mem_data_q;

        if (push) begin
            mem_rdest_d[wr_ptr_q] = i_lu_rdest;
            mem_data_d[wr_ptr_q]  = i_lu_data;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Age tracks how long the current head has been waiting for the port.
        if (pop || (push && (count_q == '0))) begin
            age_d = '0;
        end else if ((count_q != '0) && (age_q < MAX_WAIT_C)) begin
            age_d = age_q + AW'(1);
        end

        case (state_q)
            ST_NORMAL: begin
                if ((count_q == DEPTH_C) || (age_q >= MAX_WAIT_C)) begin
                    state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                if (count_d == '0) begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    // Pending-destination flags for the hazard unit; x0 is never busy.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (mem_rdest_q[idx] == i_rs1) rs1_hit = 1'b1;
                if (mem_rdest_q[idx] == i_rs2) rs2_hit = 1'b1;
            end
        end
        o_rs1_busy = i_areset_n && rs1_hit && (i_rs1 != '0);
        o_rs2_busy = i_areset_n && rs2_hit && (i_rs2 != '0);
        o_wb_stall = i_areset_n && (state_q == ST_FORCE);
        o_dbg_state = state_q;
        o_dbg_count = count_q;
    end

    // State registers with synchronous active-low reset; reset discards queued results.
    always_ff @(posedge i_aclk) begin
        if (!i_areset_n) begin
            state_q  <= ST_NORMAL;
            count_q  <= '0;
            age_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_rdest_q[k] <= '0;
                mem_data_q[k]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            age_q       <= age_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_rdest_q <= mem_rdest_d;
            mem_data_q  <= mem_data_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: single-cycle vectors from a table, then
// hand-written multi-cycle sequences for fill, aging and reset mid-drain.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_regwrite;
  logic [4:0]  wb_rdest;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rdest;
  logic [31:0] lu_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        dbg_state;
  logic [1:0]  dbg_count;

  int n_checks = 0;
  int n_errors = 0;

  wb_port_arbiter #(
    .NUM_REGS(32), .DATA_SIZE(32), .DEPTH(2), .MAX_WAIT(4)
  ) dut (
    .i_aclk(clk),
    .i_areset_n(rst_n),
    .i_wb_regwrite(wb_regwrite),
    .i_wb_rdest(wb_rdest),
    .i_wb_data(wb_data),
    .i_lu_valid(lu_valid),
    .o_lu_ready(lu_ready),
    .i_lu_rdest(lu_rdest),
    .i_lu_data(lu_data),
    .i_rs1(rs1),
    .i_rs2(rs2),
    .o_rs1_busy(rs1_busy),
    .o_rs2_busy(rs2_busy),
    .o_wb_stall(wb_stall),
    .o_rf_we(rf_we),
    .o_rf_waddr(rf_waddr),
    .o_rf_wdata(rf_wdata),
    .o_dbg_state(dbg_state),
    .o_dbg_count(dbg_count)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        regwrite;
    logic [4:0]  wb_rdest;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_rdest;
    logic [31:0] lu_data;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_ready;
    logic [1:0]  exp_count_after;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic rw, input logic [4:0] rd, input logic [31:0] d);
    wb_regwrite = rw;
    wb_rdest    = rd;
    wb_data     = d;
  endtask

  task automatic drive_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lu_valid = v;
    lu_rdest = rd;
    lu_data  = d;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we"}, {31'd0, rf_we}, {31'd0, we});
    if (we) begin
      check({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, a});
      check({tag, "_wdata"}, rf_wdata, d);
    end
  endtask

  initial begin
    // x0 write vectors and bypass vectors all leave the FIFO empty.
    vecs[0] = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd0, 32'h0,  1'b1, 5'd5,  32'h1234,     1'b1, 2'd0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'hAA, 1'b1, 5'd7,  32'hAA,       1'b1, 2'd0};
    vecs[2] = '{1'b1, 5'd0,  32'h77,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b1, 2'd0};
    vecs[3] = '{1'b1, 5'd0,  32'h77,       1'b1, 5'd9, 32'h55, 1'b1, 5'd9,  32'h55,       1'b1, 2'd0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h99, 1'b0, 5'd0,  32'h0,        1'b1, 2'd0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b1, 2'd0};
    vecs[6] = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 5'd0, 32'h11, 1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 2'd0};
    vecs[7] = '{1'b0, 5'd12, 32'hCAFE,     1'b0, 5'd3, 32'h3,  1'b0, 5'd0,  32'h0,        1'b1, 2'd0};

    // Reset held with both requesters active.
    rst_n = 1'b0;
    drive_wb(1'b1, 5'd5, 32'h1234);
    drive_lu(1'b1, 5'd3, 32'h3);
    rs1 = 5'd3;
    rs2 = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_ready", {31'd0, lu_ready}, 32'd0);
    check("rst_stall", {31'd0, wb_stall}, 32'd0);
    check("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_lu(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("rel_count", {30'd0, dbg_count}, 32'd0);
    check("rel_stall", {31'd0, wb_stall}, 32'd0);
    next_cycle();

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 8; i++) begin
      drive_wb(vecs[i].regwrite, vecs[i].wb_rdest, vecs[i].wb_data);
      drive_lu(vecs[i].lu_valid, vecs[i].lu_rdest, vecs[i].lu_data);
      @(negedge clk);
      check_rf($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_waddr, vecs[i].exp_wdata);
      check($sformatf("vec%0d_ready", i), {31'd0, lu_ready}, {31'd0, vecs[i].exp_ready});
      check($sformatf("vec%0d_stall", i), {31'd0, wb_stall}, 32'd0);
      next_cycle();
      check($sformatf("vec%0d_count", i), {30'd0, dbg_count}, {30'd0, vecs[i].exp_count_after});
    end

    // Fill: wb owns the port while lu delivers r3 then r4.
    rs1 = 5'd3;
    rs2 = 5'd0;
    drive_wb(1'b1, 5'd10, 32'h100);
    drive_lu(1'b1, 5'd3, 32'h3);
    @(negedge clk);
    check_rf("full_c1", 1'b1, 5'd10, 32'h100);
    check("full_c1_ready", {31'd0, lu_ready}, 32'd1);
    next_cycle();
    drive_wb(1'b1, 5'd11, 32'h101);
    drive_lu(1'b1, 5'd4, 32'h4);
    @(negedge clk);
    check_rf("full_c2", 1'b1, 5'd11, 32'h101);
    check("full_c2_count", {30'd0, dbg_count}, 32'd1);
    check("full_c2_rs1_busy", {31'd0, rs1_busy}, 32'd1);
    check("full_c2_rs2_busy", {31'd0, rs2_busy}, 32'd0);
    next_cycle();
    drive_wb(1'b1, 5'd12, 32'h102);
    drive_lu(1'b1, 5'd8, 32'h8);
    @(negedge clk);
    check("full_c3_count", {30'd0, dbg_count}, 32'd2);
    check("full_c3_ready", {31'd0, lu_ready}, 32'd0);
    check("full_c3_stall", {31'd0, wb_stall}, 32'd0);
    check_rf("full_c3", 1'b1, 5'd12, 32'h102);
    next_cycle();
    drive_wb(1'b1, 5'd13, 32'h103);
    drive_lu(1'b0, 5'd0, 32'h0);
    rs2 = 5'd4;
    @(negedge clk);
    check("full_c4_stall", {31'd0, wb_stall}, 32'd1);
    check_rf("full_c4", 1'b1, 5'd3, 32'h3);
    next_cycle();
    @(negedge clk);
    check("full_c5_stall", {31'd0, wb_stall}, 32'd1);
    check_rf("full_c5", 1'b1, 5'd4, 32'h4);
    check("full_c5_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    check("full_c5_rs2_busy", {31'd0, rs2_busy}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("full_c6_stall", {31'd0, wb_stall}, 32'd0);
    check("full_c6_count", {30'd0, dbg_count}, 32'd0);
    check_rf("full_c6", 1'b1, 5'd13, 32'h103);
    next_cycle();

    // Aging: one entry queued behind continuous wb writes.
    rs1 = 5'd6;
    rs2 = 5'd0;
    drive_wb(1'b1, 5'd20, 32'h200);
    drive_lu(1'b1, 5'd6, 32'h66);
    @(negedge clk);
    check_rf("age_push", 1'b1, 5'd20, 32'h200);
    next_cycle();
    drive_lu(1'b0, 5'd0, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      drive_wb(1'b1, 5'd21, 32'h210 + c);
      @(negedge clk);
      check($sformatf("age_c%0d_stall", c), {31'd0, wb_stall}, 32'd0);
      check($sformatf("age_c%0d_rs1_busy", c), {31'd0, rs1_busy}, 32'd1);
      check_rf($sformatf("age_c%0d", c), 1'b1, 5'd21, 32'h210 + c);
      next_cycle();
    end
    @(negedge clk);
    check("age_force_stall", {31'd0, wb_stall}, 32'd1);
    check_rf("age_force", 1'b1, 5'd6, 32'h66);
    next_cycle();
    @(negedge clk);
    check("age_done_stall", {31'd0, wb_stall}, 32'd0);
    check("age_done_count", {30'd0, dbg_count}, 32'd0);
    check("age_done_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    next_cycle();

    // Reset mid-drain discards queued results.
    drive_wb(1'b1, 5'd14, 32'h300);
    drive_lu(1'b1, 5'd15, 32'h15);
    next_cycle();
    drive_lu(1'b1, 5'd16, 32'h16);
    next_cycle();
    drive_lu(1'b0, 5'd0, 32'h0);
    next_cycle();
    @(negedge clk);
    check("rmd_force_stall", {31'd0, wb_stall}, 32'd1);
    check("rmd_force_count", {30'd0, dbg_count}, 32'd2);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("rmd_rst_we", {31'd0, rf_we}, 32'd0);
    check("rmd_rst_stall", {31'd0, wb_stall}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    drive_wb(1'b0, 5'd0, 32'h0);
    rs1 = 5'd16;
    @(negedge clk);
    check("rmd_rel_count", {30'd0, dbg_count}, 32'd0);
    check("rmd_rel_state", {31'd0, dbg_state}, 32'd0);
    check("rmd_rel_we", {31'd0, rf_we}, 32'd0);
    check("rmd_rel_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    next_cycle();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
